wb_regfile: RTL and testbench

//  Write-back end of the MEM/WB pipeline boundary: consumes the registered MEM/WB

---
 rtl/wb_regfile.sv | 77 +++++++
 tb/tb_wb_regfile.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage: selects ALU/load data, commits it to a 32-entry register file with
// write-through bypass on all read ports, and tracks retired instructions. Reads are 0-cycle.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_memtoreg,
  input  logic              wb_regwrite,
  input  logic [DATA_W-1:0] wb_aluout,
  input  logic [DATA_W-1:0] wb_memout,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [31:0]       wb_inst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [31:0]       last_inst
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              commit;
  logic              bypass_en;

  assign wb_data   = wb_memtoreg ? wb_memout : wb_aluout;
  assign commit    = wb_regwrite && (wb_rd != '0);
  // A write presented during reset is discarded, so it must not be forwarded either.
  assign bypass_en = commit && !rst;

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              byp,
    input logic [ADDR_W-1:0] rd,
    input logic [DATA_W-1:0] wdata
  );
    if (addr == '0)
      return '0;
    else if (byp && (rd == addr))
      return wdata;
    else
      return stored;
  endfunction

  assign rs1_data = read_port(rs1_addr, regs[rs1_addr], bypass_en, wb_rd, wb_data);
  assign rs2_data = read_port(rs2_addr, regs[rs2_addr], bypass_en, wb_rd, wb_data);
  assign dbg_data = read_port(dbg_addr, regs[dbg_addr], bypass_en, wb_rd, wb_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Bubbles (all-zero word) are not instructions; everything else retires, NOPs included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      last_inst  <= '0;
    end else if (wb_inst != 32'h0) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
      last_inst  <= wb_inst;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations are queued by the stimulus and checked by a
// negedge monitor. A narrow-counter instance exercises retire_cnt wrap-around.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_memtoreg, wb_regwrite;
  logic [31:0] wb_aluout, wb_memout, wb_inst;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr, dbg_addr;
  logic [31:0] rs1_data, rs2_data, dbg_data, wb_data, retire_cnt, last_inst;
  logic [31:0] s_rs1, s_rs2, s_dbg, s_wbd, s_last;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .wb_aluout(wb_aluout), .wb_memout(wb_memout), .wb_rd(wb_rd), .wb_inst(wb_inst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dbg_addr(dbg_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .dbg_data(dbg_data), .wb_data(wb_data),
    .retire_cnt(retire_cnt), .last_inst(last_inst)
  );

  wb_regfile #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .wb_aluout(wb_aluout), .wb_memout(wb_memout), .wb_rd(wb_rd), .wb_inst(wb_inst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dbg_addr(dbg_addr),
    .rs1_data(s_rs1), .rs2_data(s_rs2), .dbg_data(s_dbg), .wb_data(s_wbd),
    .retire_cnt(s_cnt), .last_inst(s_last)
  );

  typedef enum int {K_RS1, K_RS2, K_DBG, K_WBD, K_CNT, K_LAST, K_SCNT} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic string kname(input kind_t k);
    case (k)
      K_RS1:   return "rs1_data";
      K_RS2:   return "rs2_data";
      K_DBG:   return "dbg_data";
      K_WBD:   return "wb_data";
      K_CNT:   return "retire_cnt";
      K_LAST:  return "last_inst";
      default: return "retire_cnt_w3";
    endcase
  endfunction

  // Monitor: outputs are stable by the falling edge; drain everything queued this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RS1:   act = rs1_data;
        K_RS2:   act = rs2_data;
        K_DBG:   act = dbg_data;
        K_WBD:   act = wb_data;
        K_CNT:   act = retire_cnt;
        K_LAST:  act = last_inst;
        default: act = {29'b0, s_cnt};
      endcase
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h, expected %h", kname(e.kind), $time, act, e.val);
      end
    end
  end

  task automatic expect_val(input kind_t k, input logic [31:0] v);
    q.push_back('{kind: k, val: v});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic rw, input logic m2r, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [4:0] rd, input logic [31:0] inst);
    wb_regwrite = rw;
    wb_memtoreg = m2r;
    wb_aluout   = alu;
    wb_memout   = mem;
    wb_rd       = rd;
    wb_inst     = inst;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bundle(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd1;

    // Power-on reset state
    cyc();
    expect_val(K_CNT, 32'h0);
    expect_val(K_LAST, 32'h0);
    expect_val(K_DBG, 32'h0);
    cyc();
    rst = 1'b0;

    // Write ALU result to x7, bypass visible the same cycle, storage the next
    cyc();
    bundle(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd7, 32'h0);
    rs1_addr = 5'd7;
    expect_val(K_RS1, 32'hDEADBEEF);
    expect_val(K_WBD, 32'hDEADBEEF);
    cyc();
    bundle(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 32'h0);
    dbg_addr = 5'd7;
    expect_val(K_RS1, 32'hDEADBEEF);
    expect_val(K_DBG, 32'hDEADBEEF);

    // Load data selected over ALU result
    cyc();
    bundle(1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 5'd3, 32'h0);
    rs2_addr = 5'd3;
    expect_val(K_WBD, 32'h12345678);
    expect_val(K_RS2, 32'h12345678);
    cyc();
    bundle(1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 5'd3, 32'h0);
    dbg_addr = 5'd3;
    expect_val(K_DBG, 32'h12345678);
    expect_val(K_WBD, 32'hFFFFFFFF);

    // x0 writes dropped, x0 always reads zero
    cyc();
    bundle(1'b1, 1'b0, 32'hAAAA5555, 32'h0, 5'd0, 32'h0);
    rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
    expect_val(K_RS1, 32'h0);
    expect_val(K_RS2, 32'h0);
    expect_val(K_DBG, 32'h0);
    cyc();
    bundle(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    expect_val(K_DBG, 32'h0);
    expect_val(K_RS1, 32'h0);

    // Retirement: NOP counts, bubble does not
    cyc();
    wb_inst = 32'h00000013;
    cyc();
    wb_inst = 32'h0;
    expect_val(K_CNT, 32'd1);
    expect_val(K_LAST, 32'h00000013);
    cyc();
    wb_inst = 32'h00A00093;
    expect_val(K_CNT, 32'd1);
    expect_val(K_LAST, 32'h00000013);
    cyc();
    wb_inst = 32'h0;
    expect_val(K_CNT, 32'd2);
    expect_val(K_LAST, 32'h00A00093);
    expect_val(K_SCNT, 32'd2);

    // Drive the 3-bit counter from 2 through 7 and wrap to 0
    for (int i = 0; i < 6; i++) begin
      cyc();
      wb_inst = 32'h00000013;
    end
    cyc();
    wb_inst = 32'h0;
    expect_val(K_SCNT, 32'd0);
    expect_val(K_CNT, 32'd8);
    expect_val(K_LAST, 32'h00000013);

    // Both read ports hitting the in-flight destination
    cyc();
    bundle(1'b1, 1'b0, 32'h1, 32'h0, 5'd9, 32'h0);
    rs1_addr = 5'd9; rs2_addr = 5'd9; dbg_addr = 5'd9;
    expect_val(K_RS1, 32'h1);
    expect_val(K_RS2, 32'h1);
    expect_val(K_DBG, 32'h1);
    cyc();
    bundle(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    expect_val(K_RS1, 32'h1);
    expect_val(K_RS2, 32'h1);

    // Mid-run reset with a write to x5 pending
    cyc();
    rst = 1'b1;
    bundle(1'b1, 1'b0, 32'h55555555, 32'h0, 5'd5, 32'h00000013);
    dbg_addr = 5'd5; rs1_addr = 5'd7; rs2_addr = 5'd3;
    expect_val(K_DBG, 32'h0);
    expect_val(K_RS1, 32'h0);
    expect_val(K_RS2, 32'h0);
    expect_val(K_CNT, 32'h0);
    expect_val(K_LAST, 32'h0);
    cyc();
    dbg_addr = 5'd9;
    expect_val(K_DBG, 32'h0);
    expect_val(K_CNT, 32'h0);
    cyc();
    rst = 1'b0;
    bundle(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    dbg_addr = 5'd5;
    expect_val(K_DBG, 32'h0);
    cyc();
    expect_val(K_DBG, 32'h0);
    expect_val(K_CNT, 32'h0);
    expect_val(K_LAST, 32'h0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
